pwm_duty_meter: RTL and testbench
=================================

// Module: pwm_duty_meter
// PURPOSE
//  Downstream monitor for the pwm generator: samples its pwm_out, measures period and
//  high time in clk cycles, computes integer duty percent (0..100), one result per period.
//  Closes the loop on duty_percent/period programming; detects a stuck-high/low output.
// PARAMETERS
//  CNT_W        32         width of period/high counters and outputs
//  SYNC_STAGES  2          synchroniser flops on pwm_in (>=2)
//  TIMEOUT      1_000_000  clk cycles with no rising edge before declaring stuck
// PORTS
//  clk           in   1      clock, all logic on rising edge
//  nrst          in   1      synchronous active-low reset
//  pwm_in        in   1      PWM signal under test (async-safe)
//  enable        in   1      1 = measure; 0 = idle, counters cleared
//  period_out    out  CNT_W  cycles between last two rising edges (0 when stuck)
//  high_out      out  CNT_W  cycles input was high within that period
//  duty_percent  out  7      floor(high_out*100/period_out); 0/100 when stuck
//  meas_valid    out  1      1-cycle pulse: outputs above updated this cycle
//  stuck         out  1      level: no rising edge for TIMEOUT cycles
//  overrun       out  1      sticky: period completed while divider busy; clr by !enable
// BEHAVIOUR
//  - Reset (nrst=0 at clk edge): all outputs 0, state IDLE, counters 0.
//  - pwm_in passes SYNC_STAGES flops; rise/fall detect on synced value (s, s_d).
//  - FSM: IDLE -(enable)-> ARM -(rise)-> MEAS; MEAS -(rise)-> MEAS (capture);
//    ARM/MEAS -(no rise for TIMEOUT)-> STUCK; STUCK -(rise)-> MEAS; any -(!enable)-> IDLE.
//  - First rise after ARM only starts counting; no result for the partial period.
//  - Period = cycles from one synced rise to the next; high = cycles with s=1 in that span.
//    Counters saturate at 2^CNT_W-1, never wrap.
//  - On each rise in MEAS: latch period/high into divider if idle; if divider busy,
//    drop the sample and set overrun. Counting of the new period starts same cycle.
//  - Divider: restoring, 7 iterations, compares high*100 (CNT_W+7 bits) with period<<i,
//    i=6..0. high<=period guarantees quotient<=100.
//  - Latency: meas_valid exactly 9 clk after the cycle the synced rise is detected
//    (1 capture, 7 divide, 1 output reg). period_out/high_out/duty_percent update together
//    with meas_valid and hold until the next pulse.
//  - STUCK entry: stuck=1, period_out=0, high_out=0, duty_percent=100 if s=1 else 0,
//    one meas_valid pulse. stuck clears on next rise; result after following full period.
//  - enable falling mid-period or mid-divide: abort, no meas_valid, outputs hold, overrun
//    clears, stuck clears.
//  - period_out==0 cannot reach divider (min period 2 cycles); period of 1 impossible
//    after edge detect.
// STRUCTURE
//  - pwm_pkg: DUTY_W=7, PCT_SCALE=100, state encoding (IDLE/ARM/MEAS/STUCK), DIV_ITERS=7.
//  - Sub-module pwm_duty_div: start/busy/done handshake, in high/period, out duty[6:0].
//  - Top: synchroniser, edge detect, counters, timeout counter, FSM, output registers.
// TESTING
//  - Ideal PWM period 20, high 2, enable=1 -> from 2nd rise: period_out=20, high_out=2,
//    duty=10, meas_valid every 20 cycles, 9 cycles after each detected rise.
//  - period 3, high 1 -> duty 33 (floor); period 7, high 7? not possible; high 6 -> 85.
//  - pwm_in held 1 for TIMEOUT (bench TIMEOUT=100) -> stuck=1, duty=100, period_out=0,
//    single meas_valid; held 0 -> duty=0. Rise restores stuck=0.
//  - Period 4 (< divider latency) -> overrun=1 sticky, results every other period valid.
//  - Drop enable mid-divide -> no meas_valid, outputs unchanged, overrun=0; re-enable ->
//    first result after one discarded partial period.
//  - nrst=0 mid-measurement -> next clk all outputs 0, FSM IDLE; glitch-free restart.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared constants and FSM state encoding for the PWM duty
//                meter and its duty-cycle divider.
//  Revision    : 1.0  initial release
// ============================================================================
package pwm_pkg;

    // Width of the duty-percent result (0..100 fits in 7 bits)
    localparam int DUTY_W    = 7;
    // Scale factor turning a high/period ratio into percent
    localparam int PCT_SCALE = 100;
    // One quotient bit resolved per divider iteration
    localparam int DIV_ITERS = 7;

    // Measurement FSM encoding
    localparam int              ST_W     = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_ARM   = 2'd1;
    localparam logic [ST_W-1:0] ST_MEAS  = 2'd2;
    localparam logic [ST_W-1:0] ST_STUCK = 2'd3;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_duty_div.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_div
//  Description : Restoring divider computing floor(high*100/period). Resolves
//                one quotient bit per clock, MSB first, over DIV_ITERS cycles.
//                start_i is accepted only while idle; done_o pulses for one
//                cycle with duty_o valid. abort_i drops any division in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              abort_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  high_i,
    input  logic [CNT_W-1:0]  period_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DUTY_W-1:0] duty_o
);

    localparam int REM_W = CNT_W + DUTY_W;
    localparam int IT_W  = $clog2(DIV_ITERS);

    logic [REM_W-1:0]  rem_q;
    logic [CNT_W-1:0]  div_q;
    logic [DUTY_W-1:0] quo_q;
    logic [IT_W-1:0]   iter_q;
    logic              busy_q;
    logic              done_q;

    logic [REM_W-1:0]  w_trial;
    logic              w_ge;

    // Trial subtrahend for the current quotient bit: period shifted by bit index
    always_comb begin
        w_trial = REM_W'(div_q) << iter_q;
        w_ge    = (rem_q >= w_trial);
    end

    // Load operands on start, then one restoring step per cycle down to bit 0
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                if (w_ge) begin
                    rem_q         <= rem_q - w_trial;
                    quo_q[iter_q] <= 1'b1;
                end
                if (iter_q == '0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    iter_q <= iter_q - IT_W'(1);
                end
            end else if (start_i) begin
                // high <= period, so high*100 < period*128 and the quotient fits 7 bits
                rem_q  <= REM_W'(high_i) * REM_W'(PCT_SCALE);
                div_q  <= period_i;
                quo_q  <= '0;
                iter_q <= IT_W'(DIV_ITERS - 1);
                busy_q <= 1'b1;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign duty_o = quo_q;

endmodule : pwm_duty_div
`default_nettype wire

// File: rtl/pwm_duty_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_meter
//  Description : Measures period, high time and integer duty percent of an
//                asynchronous PWM input, one result per completed period.
//                Flags a stuck output when no rising edge is seen for TIMEOUT
//                cycles and a sticky overrun when a period completes while the
//                divider is still busy with the previous one.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1_000_000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              pwm_in,
    input  logic              enable,
    output logic [CNT_W-1:0]  period_out,
    output logic [CNT_W-1:0]  high_out,
    output logic [DUTY_W-1:0] duty_percent,
    output logic              meas_valid,
    output logic              stuck,
    output logic              overrun
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    // Synchroniser and edge detect
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   w_s;
    logic                   w_rise;

    // FSM
    logic [ST_W-1:0]        state_q;
    logic [ST_W-1:0]        state_d;

    // Counters
    logic [CNT_W-1:0]       period_cnt_q;
    logic [CNT_W-1:0]       high_cnt_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic                   w_timeout;

    // Captured operands travelling alongside the divider
    logic [CNT_W-1:0]       cap_period_q;
    logic [CNT_W-1:0]       cap_high_q;

    // FSM decode
    logic                   w_capture;
    logic                   w_stuck_enter;
    logic                   w_stuck_exit;
    logic                   w_div_start;
    logic                   w_ovr_set;

    // Divider interface
    logic                   w_div_busy;
    logic                   w_div_done;
    logic [DUTY_W-1:0]      w_div_duty;

    // Output registers
    logic [CNT_W-1:0]       period_out_q;
    logic [CNT_W-1:0]       high_out_q;
    logic [DUTY_W-1:0]      duty_q;
    logic                   meas_valid_q;
    logic                   stuck_q;
    logic                   overrun_q;

    // Bring pwm_in into the clk domain and keep one delayed copy for edge detect
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign w_s       = sync_q[SYNC_STAGES-1];
    assign w_rise    = w_s & ~s_d_q;
    assign w_timeout = (to_cnt_q == TO_W'(TIMEOUT - 1));

    // Period/high counters: restart at 1 on each rise so the rise cycle belongs to the new period
    always_ff @(posedge clk) begin
        if (!nrst || !enable || (state_q == ST_IDLE)) begin
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
        end else if (w_rise) begin
            period_cnt_q <= CNT_W'(1);
            high_cnt_q   <= CNT_W'(1);
        end else begin
            if (!(&period_cnt_q)) begin
                period_cnt_q <= period_cnt_q + CNT_W'(1);
            end
            if (w_s && !(&high_cnt_q)) begin
                high_cnt_q <= high_cnt_q + CNT_W'(1);
            end
        end
    end

    // Cycles since the last rise while waiting for edges (ARM/MEAS only)
    always_ff @(posedge clk) begin
        if (!nrst || !enable || w_rise ||
            (state_q == ST_IDLE) || (state_q == ST_STUCK)) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_ARM;
                ST_ARM,
                ST_MEAS: begin
                    if (w_rise) begin
                        state_d = ST_MEAS;
                    end else if (w_timeout) begin
                        state_d = ST_STUCK;
                    end
                end
                ST_STUCK: begin
                    if (w_rise) begin
                        state_d = ST_MEAS;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output decode: which events this cycle's state and edge produce
    always_comb begin
        w_capture     = 1'b0;
        w_stuck_enter = 1'b0;
        w_stuck_exit  = 1'b0;
        if (enable) begin
            case (state_q)
                ST_ARM:   w_stuck_enter = !w_rise && w_timeout;
                ST_MEAS: begin
                    w_capture     = w_rise;
                    w_stuck_enter = !w_rise && w_timeout;
                end
                ST_STUCK: w_stuck_exit = w_rise;
                default: ;
            endcase
        end
    end

    assign w_div_start = w_capture && !w_div_busy;
    assign w_ovr_set   = w_capture &&  w_div_busy;

    // Hold the completed period's counts until the divider reports its quotient
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cap_period_q <= '0;
            cap_high_q   <= '0;
        end else if (w_div_start) begin
            cap_period_q <= period_cnt_q;
            cap_high_q   <= high_cnt_q;
        end
    end

    pwm_duty_div #(
        .CNT_W    (CNT_W)
    ) u_div (
        .clk      (clk),
        .nrst     (nrst),
        .abort_i  (!enable),
        .start_i  (w_div_start),
        .high_i   (high_cnt_q),
        .period_i (period_cnt_q),
        .busy_o   (w_div_busy),
        .done_o   (w_div_done),
        .duty_o   (w_div_duty)
    );

    // Result, stuck and overrun registers; outputs hold across disable
    always_ff @(posedge clk) begin
        if (!nrst) begin
            period_out_q <= '0;
            high_out_q   <= '0;
            duty_q       <= '0;
            meas_valid_q <= 1'b0;
            stuck_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            if (!enable) begin
                stuck_q   <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                if (w_ovr_set) begin
                    overrun_q <= 1'b1;
                end
                if (w_stuck_enter) begin
                    stuck_q      <= 1'b1;
                    period_out_q <= '0;
                    high_out_q   <= '0;
                    duty_q       <= w_s ? DUTY_W'(PCT_SCALE) : '0;
                    meas_valid_q <= 1'b1;
                end else if (w_div_done) begin
                    period_out_q <= cap_period_q;
                    high_out_q   <= cap_high_q;
                    duty_q       <= w_div_duty;
                    meas_valid_q <= 1'b1;
                end
                if (w_stuck_exit) begin
                    stuck_q <= 1'b0;
                end
            end
        end
    end

    assign period_out   = period_out_q;
    assign high_out     = high_out_q;
    assign duty_percent = duty_q;
    assign meas_valid   = meas_valid_q;
    assign stuck        = stuck_q;
    assign overrun      = overrun_q;

endmodule : pwm_duty_meter
`default_nettype wire

// File: tb/tb_pwm_duty_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_duty_meter
//  Description : Scoreboard bench for pwm_duty_meter. Stimulus pushes the
//                hand-computed result of each closed period; a monitor pops
//                and compares on every meas_valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_duty_meter;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 100;
    localparam int LAT     = 11;   // 2 sync edges + 9 processing edges

    typedef struct {
        logic [31:0] period;
        logic [31:0] high;
        logic [6:0]  duty;
        logic        stuck;
        int          cyc;          // 0 = arrival cycle not checked
    } exp_t;

    logic             clk;
    logic             nrst;
    logic             pwm_in;
    logic             enable;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic [6:0]       duty_percent;
    logic             meas_valid;
    logic             stuck;
    logic             overrun;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests;
    int   n_fail;
    int   cyc;
    bit   have_prev;
    int   prev_p;
    int   prev_h;
    int   prev_duty;

    pwm_duty_meter #(
        .CNT_W        (CNT_W),
        .SYNC_STAGES  (2),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .pwm_in       (pwm_in),
        .enable       (enable),
        .period_out   (period_out),
        .high_out     (high_out),
        .duty_percent (duty_percent),
        .meas_valid   (meas_valid),
        .stuck        (stuck),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every meas_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_meas_valid: pulse at cycle %0d (period=%0d high=%0d duty=%0d), required none",
                         cyc, period_out, high_out, duty_percent);
            end else begin
                mon_e = sb.pop_front();
                n_tests++;
                if (period_out !== mon_e.period || high_out !== mon_e.high ||
                    duty_percent !== mon_e.duty || stuck !== mon_e.stuck) begin
                    n_fail++;
                    $display("FAIL result: got period=%0d high=%0d duty=%0d stuck=%0b, required period=%0d high=%0d duty=%0d stuck=%0b",
                             period_out, high_out, duty_percent, stuck,
                             mon_e.period, mon_e.high, mon_e.duty, mon_e.stuck);
                end
                if (mon_e.cyc != 0) begin
                    n_tests++;
                    if (cyc != mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL latency: meas_valid at cycle %0d, required %0d", cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // One PWM period starting with a rise; the rise closes the previous period
    task automatic pwm_cycle(input int p, input int h, input int duty, input bit push_ok);
        exp_t e;
        @(posedge clk);
        #1;
        if (have_prev && push_ok) begin
            e.period = 32'(prev_p);
            e.high   = 32'(prev_h);
            e.duty   = 7'(prev_duty);
            e.stuck  = 1'b0;
            e.cyc    = cyc + LAT;
            sb.push_back(e);
        end
        pwm_in = 1'b1;
        repeat (h) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (p - h - 1) @(posedge clk);
        have_prev = 1'b1;
        prev_p    = p;
        prev_h    = h;
        prev_duty = duty;
    endtask

    task automatic push_stuck(input logic [6:0] duty);
        exp_t e;
        e.period = '0;
        e.high   = '0;
        e.duty   = duty;
        e.stuck  = 1'b1;
        e.cyc    = 0;
        sb.push_back(e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results pending after %0d cycles, required 0", sb.size(), k);
            sb.delete();
        end
    endtask

    task automatic wait_stuck();
        int k;
        k = 0;
        while (stuck !== 1'b1 && k < 3 * TIMEOUT) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("stuck_asserted", 64'(stuck), 64'd1);
        check("stuck_period_zero", 64'(period_out), 64'd0);
    endtask

    task automatic rearm();
        drain();
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enable    = 1'b1;
        have_prev = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        have_prev = 1'b0;
        prev_p    = 0;
        prev_h    = 0;
        prev_duty = 0;
        nrst      = 1'b0;
        enable    = 1'b0;
        pwm_in    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", 64'(period_out), 64'd0);
        check("rst_high", 64'(high_out), 64'd0);
        check("rst_duty", 64'(duty_percent), 64'd0);
        check("rst_flags", 64'({meas_valid, stuck, overrun}), 64'd0);
        nrst   = 1'b1;
        enable = 1'b1;

        // Period 20 / high 2 -> 10 %, first period discarded
        repeat (4) pwm_cycle(20, 2, 10, 1'b1);

        // Period 3 / high 1 -> 33 %, closed by a long period
        rearm();
        pwm_cycle(3, 1, 33, 1'b1);
        pwm_cycle(20, 2, 10, 1'b1);

        // Period 7 / high 6 -> 85 %
        rearm();
        pwm_cycle(7, 6, 85, 1'b1);
        pwm_cycle(20, 2, 10, 1'b1);

        // Stuck high -> duty 100, then recovery
        rearm();
        push_stuck(7'd100);
        @(posedge clk);
        #1;
        pwm_in = 1'b1;
        wait_stuck();
        repeat (20) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        have_prev = 1'b0;
        pwm_cycle(20, 2, 10, 1'b1);
        check("stuck_cleared", 64'(stuck), 64'd0);
        pwm_cycle(20, 2, 10, 1'b1);

        // Stuck low -> duty 0; disable clears stuck
        rearm();
        push_stuck(7'd0);
        wait_stuck();
        rearm();
        check("stuck_clr_by_disable", 64'(stuck), 64'd0);

        // Period 4 shorter than divider latency: every other period measured
        pwm_cycle(4, 1, 25, 1'b0);
        pwm_cycle(4, 1, 25, 1'b1);
        pwm_cycle(4, 1, 25, 1'b0);
        pwm_cycle(4, 1, 25, 1'b1);
        pwm_cycle(4, 1, 25, 1'b0);
        pwm_cycle(4, 1, 25, 1'b1);
        check("overrun_set", 64'(overrun), 64'd1);
        rearm();
        check("overrun_clr_by_disable", 64'(overrun), 64'd0);

        // Drop enable mid-divide: no result, outputs hold at 4/1/25
        pwm_cycle(20, 2, 10, 1'b0);
        @(posedge clk);
        #1;
        pwm_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_hold_period", 64'(period_out), 64'd4);
        check("abort_hold_high", 64'(high_out), 64'd1);
        check("abort_hold_duty", 64'(duty_percent), 64'd25);
        check("abort_flags", 64'({stuck, overrun}), 64'd0);
        enable    = 1'b1;
        have_prev = 1'b0;
        repeat (3) pwm_cycle(10, 5, 50, 1'b1);

        // Reset mid-divide: outputs zero on the next edge, clean restart
        rearm();
        pwm_cycle(20, 2, 10, 1'b0);
        @(posedge clk);
        #1;
        pwm_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_duty", 64'(duty_percent), 64'd50);
        nrst   = 1'b0;
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_period", 64'(period_out), 64'd0);
        check("midrst_high", 64'(high_out), 64'd0);
        check("midrst_duty", 64'(duty_percent), 64'd0);
        check("midrst_flags", 64'({meas_valid, stuck, overrun}), 64'd0);
        nrst      = 1'b1;
        have_prev = 1'b0;
        repeat (3) @(posedge clk);
        repeat (3) pwm_cycle(20, 2, 10, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pwm_duty_meter
`default_nettype wire
